// File: rtl/inm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with a 2-entry output queue.
// Define INM_GEN_CSR_EN to decode CSR zimm (fmt Z); otherwise SYSTEM is illegal.
module inm_gen_pipe #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [XLEN-1:0] dec_inm;
    logic [XLEN-1:0] dec_target;
    fmt_e            dec_fmt;
    logic            dec_illegal;

    always_comb begin
        dec_inm     = '0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        if (in_inst[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (in_inst[6:0])
                OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
                    dec_fmt = FMT_I;
                    dec_inm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
                end
                OPC_STORE: begin
                    dec_fmt = FMT_S;
                    dec_inm = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                end
                OPC_BRANCH: begin
                    dec_fmt = FMT_B;
                    dec_inm = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7],
                               in_inst[30:25], in_inst[11:8], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    dec_fmt = FMT_U;
                    dec_inm = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
                end
                OPC_JAL: begin
                    dec_fmt = FMT_J;
                    dec_inm = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                               in_inst[20], in_inst[30:21], 1'b0};
                end
                OPC_OP: begin
                    dec_fmt = FMT_NONE;
                end
                OPC_SYSTEM: begin
`ifdef INM_GEN_CSR_EN
                    if (in_inst[14]) begin
                        dec_fmt = FMT_Z;
                        dec_inm = {{(XLEN-5){1'b0}}, in_inst[19:15]};
                    end
`else
                    dec_illegal = 1'b1;
`endif
                end
                default: begin
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    assign dec_target = in_pc + dec_inm;

    // Output queue: 2-entry circular buffer, 1-bit pointers wrap 1 -> 0.
    logic [XLEN-1:0] inm_q     [2];
    logic [XLEN-1:0] target_q  [2];
    fmt_e            fmt_q     [2];
    logic            illegal_q [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;
    logic            push;
    logic            pop;

    assign in_ready  = (count < 2'd2) && rst_n;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int unsigned i = 0; i < 2; i++) begin
                inm_q[i]     <= '0;
                target_q[i]  <= '0;
                fmt_q[i]     <= FMT_NONE;
                illegal_q[i] <= 1'b0;
            end
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                inm_q[wr_ptr]     <= dec_inm;
                target_q[wr_ptr]  <= dec_target;
                fmt_q[wr_ptr]     <= dec_fmt;
                illegal_q[wr_ptr] <= dec_illegal;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Data outputs are forced to zero whenever the queue is empty.
    always_comb begin
        out_inm     = '0;
        out_target  = '0;
        out_fmt     = FMT_NONE;
        out_illegal = 1'b0;
        if (out_valid) begin
            out_inm     = inm_q[rd_ptr];
            out_target  = target_q[rd_ptr];
            out_fmt     = fmt_q[rd_ptr];
            out_illegal = illegal_q[rd_ptr];
        end
    end

endmodule

// File: tb/tb_inm_gen_pipe.sv
// Directed self-checking bench for inm_gen_pipe (XLEN = 32).
module tb_inm_gen_pipe;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_inm;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_target;
    logic            out_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    // {valid, illegal, fmt, inm, target}
    logic [68:0] obs;
    assign obs = {out_valid, out_illegal, out_fmt, out_inm, out_target};

    inm_gen_pipe #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inm    (out_inm),
        .out_fmt    (out_fmt),
        .out_target (out_target),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [68:0] ent(input logic ill, input logic [2:0] f,
                                        input logic [31:0] inm, input logic [31:0] tgt);
        return {1'b1, ill, f, inm, tgt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        tick(); tick();
        n_tests++;
        if (obs !== 69'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, 69'd0);
        end
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_addi();
        logic [68:0] exp;
        out_ready = 1'b1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL addi_pre_empty: got %b expected 0", out_valid);
        end
        offer(32'hFFF00093, 32'h0);
        tick();
        in_valid = 1'b0;
        exp = ent(1'b0, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        n_tests++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL addi_entry: got %h expected %h", obs, exp);
        end
        tick();
        n_tests++;
        if (obs !== 69'd0) begin
            n_fail++; $display("FAIL addi_drained: got %h expected %h", obs, 69'd0);
        end
    endtask

    task automatic test_formats();
        logic [31:0] t_inst [11];
        logic [31:0] t_pc   [11];
        logic [68:0] t_exp  [11];
        t_inst = '{32'hFE512C23, 32'h12345037, 32'h80000017, 32'h00008067, 32'h80002083,
                   32'h00000033, 32'h00000000, 32'h00000012, 32'h300AD0F3, 32'h00000073,
                   32'h8000006F};
        t_pc   = '{32'h1000, 32'h10, 32'h80000000, 32'h40, 32'h900,
                   32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h100000};
        t_exp[0]  = ent(1'b0, 3'd2, 32'hFFFFFFF8, 32'h00000FF8);
        t_exp[1]  = ent(1'b0, 3'd4, 32'h12345000, 32'h12345010);
        t_exp[2]  = ent(1'b0, 3'd4, 32'h80000000, 32'h00000000);
        t_exp[3]  = ent(1'b0, 3'd1, 32'h0, 32'h40);
        t_exp[4]  = ent(1'b0, 3'd1, 32'hFFFFF800, 32'h100);
        t_exp[5]  = ent(1'b0, 3'd0, 32'h0, 32'h44);
        t_exp[6]  = ent(1'b1, 3'd0, 32'h0, 32'h48);
        t_exp[7]  = ent(1'b1, 3'd0, 32'h0, 32'h4C);
`ifdef INM_GEN_CSR_EN
        t_exp[8]  = ent(1'b0, 3'd6, 32'd21, 32'h65);
        t_exp[9]  = ent(1'b0, 3'd0, 32'h0, 32'h54);
`else
        t_exp[8]  = ent(1'b1, 3'd0, 32'h0, 32'h50);
        t_exp[9]  = ent(1'b1, 3'd0, 32'h0, 32'h54);
`endif
        t_exp[10] = ent(1'b0, 3'd5, 32'hFFF00000, 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            offer(t_inst[i], t_pc[i]);
            tick();
            in_valid = 1'b0;
            n_tests++;
            if (obs !== t_exp[i]) begin
                n_fail++;
                $display("FAIL format_%0d inst %h: got %h expected %h", i, t_inst[i], obs, t_exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [68:0] exp;
        out_ready = 1'b1;
        offer(32'h0080006F, 32'h100);
        tick();
        exp = ent(1'b0, 3'd5, 32'd8, 32'h108);
        n_tests++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL b2b_jal: got %h expected %h", obs, exp);
        end
        offer(32'hFE000EE3, 32'h200);
        tick();
        in_valid = 1'b0;
        exp = ent(1'b0, 3'd3, 32'hFFFFFFFC, 32'h1FC);
        n_tests++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL b2b_beq: got %h expected %h", obs, exp);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drained: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        offer(32'h00100093, 32'h0);
        tick();
        offer(32'h00200093, 32'h0);
        tick();
        offer(32'h00300093, 32'h0);
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_full_ready: got %b expected 0", in_ready);
        end
        tick();
        n_tests++;
        if ({in_ready, obs} !== {1'b0, ent(1'b0, 3'd1, 32'd1, 32'd1)}) begin
            n_fail++; $display("FAIL bp_hold: got %b %h expected 0 %h", in_ready, obs, ent(1'b0, 3'd1, 32'd1, 32'd1));
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if ({in_ready, obs} !== {1'b1, ent(1'b0, 3'd1, 32'd2, 32'd2)}) begin
            n_fail++; $display("FAIL bp_second: got %b %h expected 1 %h", in_ready, obs, ent(1'b0, 3'd1, 32'd2, 32'd2));
        end
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (obs !== ent(1'b0, 3'd1, 32'd3, 32'd3)) begin
            n_fail++; $display("FAIL bp_third: got %h expected %h", obs, ent(1'b0, 3'd1, 32'd3, 32'd3));
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drained: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        offer(32'h00100093, 32'h0);
        tick();
        offer(32'h00200093, 32'h0);
        tick();
        flush = 1'b1;
        offer(32'h00700093, 32'h0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL flush_full: got valid %b ready %b expected valid 0 ready 1", out_valid, in_ready);
        end
        tick();
        n_tests++;
        if (obs !== 69'd0) begin
            n_fail++; $display("FAIL flush_full_after: got %h expected %h", obs, 69'd0);
        end
        offer(32'h00100093, 32'h0);
        tick();
        flush = 1'b1;
        offer(32'h00700093, 32'h0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (obs !== 69'd0) begin
            n_fail++; $display("FAIL flush_push_dropped: got %h expected %h", obs, 69'd0);
        end
        out_ready = 1'b1;
        offer(32'h00500093, 32'h10);
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (obs !== ent(1'b0, 3'd1, 32'd5, 32'h15)) begin
            n_fail++; $display("FAIL flush_recover: got %h expected %h", obs, ent(1'b0, 3'd1, 32'd5, 32'h15));
        end
        tick();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        offer(32'h00100093, 32'h0);
        tick();
        offer(32'h00200093, 32'h0);
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        n_tests++;
        if ({in_ready, obs} !== 70'd0) begin
            n_fail++; $display("FAIL midreset_outputs: got %b %h expected 0 %h", in_ready, obs, 69'd0);
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++; $display("FAIL midreset_release: got ready %b valid %b expected ready 1 valid 0", in_ready, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_formats();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/inm_gen_pipe.md
# inm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts one 32-bit RV32I/RV64I instruction word plus its PC per cycle over a valid/ready handshake. It extracts and extends the immediate for I/S/B/U/J formats (and optionally CSR zimm), computes the PC-relative target, and classifies the format. Results are buffered in a 2-entry output queue so the fetch and execute sides can stall independently.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active low.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept; `in_ready = (count < 2) && rst_n`.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- out_inm  out  XLEN  extended immediate.
- out_fmt  out  3  encoding: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
- out_target  out  XLEN  `in_pc + out_inm`, modulo 2^XLEN.
- out_illegal  out  1  opcode not supported.

## Operation
- Decode is combinational on the `in_*` signals. The results `{inm, fmt, target, illegal}` are written into the queue on push.
- **I** format:
  - Opcodes LOAD 0000011, OP-IMM 0010011, JALR 1100111.
  - `inm = sext(inst[31:20])`.
- **S** format: STORE 0100011; `inm = sext({inst[31:25], inst[11:7]})`.
- **B** format: BRANCH 1100011; `inm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})`.
- **U** format: LUI 0110111, AUIPC 0010111; `inm = sext({inst[31:12], 12'b0})`. Bit 31 extends to XLEN when XLEN = 64.
- **J** format: JAL 1101111; `inm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})`.
- OP 0110011: fmt NONE, inm 0, illegal 0.
- SYSTEM 1110011: handling depends on configuration (see Configuration).
- Any other opcode, or `inst[1:0] != 2'b11`: illegal 1, fmt NONE, inm 0.
- All sign extension replicates `inst[31]` up to XLEN-1.
- Target is always computed as `pc + inm`. Overflow wraps; no overflow flag is produced.
- Queue:
  - Circular 2-entry buffer with write pointer, read pointer and 2-bit count.
  - Pointers wrap 1 → 0.
  - Push when `in_valid && in_ready`; pop when `out_valid && out_ready`.
- Outputs present the head entry. When empty, all data outputs read 0.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - count 0, pointers 0, out_valid 0, all data outputs 0.
  - in_ready is 0 while rst_n is low and 1 on the first cycle after release.
- Latency: instruction pushed at edge N appears with out_valid = 1 in cycle N+1. Throughput is 1 per cycle.
- Simultaneous push and pop:
  - count 1: count stays 1. The new entry becomes head after the current head pops.
  - count 0: the entry appears at N+1; no bypass in the same cycle.
- Full (count 2): in_ready = 0 and in_valid is ignored. A pop in that cycle frees a slot from the next cycle onward; in_ready is derived from count, not from out_ready.
- Empty: out_valid = 0 and out_ready is ignored.
- flush:
  - Takes priority over push and pop in the same cycle.
  - Next cycle: count 0, out_valid 0, in_ready 1.
  - The instruction offered during the flush cycle is dropped.
- Reset has priority over flush. Reset mid-stream discards all entries.
- out_* signals are stable while `out_valid && !out_ready`.

## Configuration
- `INM_GEN_CSR_EN` defined: SYSTEM with `inst[14]` = 1 gives fmt Z, `inm = zext(inst[19:15])`, illegal 0.
  - SYSTEM with `inst[14]` = 0 (ECALL, CSRRW, …) gives fmt NONE, inm 0, illegal 0.
- `INM_GEN_CSR_EN` undefined: every SYSTEM opcode gives illegal 1, fmt NONE, inm 0.

## Test plan
- ADDI: in_inst 0xFFF00093, pc 0x0 → next cycle out_inm 0xFFFFFFFF (all ones for XLEN = 64), fmt 1, target 0xFFFFFFFF.
- JAL then BEQ back-to-back:
  - in_inst 0x0080006F, pc 0x100 → inm 8, fmt 5, target 0x108.
  - in_inst 0xFE000EE3, pc 0x200 → inm −4, fmt 3, target 0x1FC.
  - Consecutive cycles, out_ready held 1.
- Backpressure:
  - out_ready 0, three instructions offered → first two accepted, in_ready 0 from the third cycle.
  - Raise out_ready → entries drain in order, one per cycle, and the third is then accepted.
- Flush: count 2 plus push asserted in the same cycle as flush → next cycle out_valid 0, in_ready 1, and the pushed word never appears.
- CSRRWI 0x300AD0F3:
  - With `INM_GEN_CSR_EN`: fmt 6, inm 21, illegal 0.
  - Without: illegal 1, inm 0.
- Illegal and reset:
  - in_inst 0x00000000 → illegal 1, fmt 0, inm 0.
  - Assert rst_n = 0 with entries queued → next cycle out_valid 0 and all outputs 0.
